alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer in front of a single shared `ALU_design` instance. It accepts operation requests over valid/ready handshakes and drives the ALU operand and command ports with `ALU_CE` gating. It counts the command-dependent ALU latency and returns the captured ALU flags and result, tagged with the requester ID, over a valid/ready response port. Only one operation is in flight at a time.

## Interface
- `WIDTH`, 8: operand width; the result width is 2*WIDTH.
- `CMD_WIDTH`, 4: command width.
- `LAT_ALU`, 1: number of ALU_CE cycles for single-cycle commands.
- `LAT_MUL`, 3: number of ALU_CE cycles for MODE=1 CMD=9 and CMD=10 (multiply commands).

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `REQn_VALID` in 1 (n=0,1): request valid.
- `REQn_READY` out 1: request accepted this cycle.
- `REQn_OPA`, `REQn_OPB` in WIDTH: operands.
- `REQn_INP_VALID` in 2, `REQn_CIN` in 1, `REQn_MODE` in 1, `REQn_CMD` in CMD_WIDTH: ALU controls.
- `ALU_CE` out 1: ALU clock enable.
- `ALU_OPA`, `ALU_OPB` out WIDTH; `ALU_INP_VALID` out 2; `ALU_CIN`, `ALU_MODE` out 1; `ALU_CMD` out CMD_WIDTH.
- `ALU_RES` in 2*WIDTH; `ALU_ERR`, `ALU_COUT`, `ALU_OFLOW`, `ALU_G`, `ALU_E`, `ALU_L` in 1.
- `RSP_VALID` out 1, `RSP_READY` in 1, `RSP_ID` out 1.
- `RSP_RES` out 2*WIDTH; `RSP_ERR`, `RSP_COUT`, `RSP_OFLOW`, `RSP_G`, `RSP_E`, `RSP_L` out 1.
- `BUSY` out 1: high in every state except IDLE.

## Operation
- FSM states are IDLE, EXEC, CAPT and RESP.
- **IDLE**
  - With one REQn_VALID high, that requester is granted.
  - With both high, the requester other than `last_grant` is granted.
  - `REQn_READY` = (state==IDLE) & grant==n. It is combinational from the VALIDs, and at most one READY is high.
  - On handshake (VALID&READY):
    - The payload is latched into operand registers.
    - `last_grant` is set to n.
    - The latency counter is loaded with LAT_MUL for MODE=1 with CMD 9 or 10, and with LAT_ALU otherwise.
    - The FSM goes to EXEC.
- **EXEC**
  - ALU_* outputs are driven from the operand registers and held stable.
  - ALU_CE=1.
  - The counter decrements each cycle; the FSM goes to CAPT after the final count.
- **CAPT**
  - ALU_CE=0; the ALU holds its outputs while CE is low.
  - At the end of the cycle, the ALU_RES/flags are registered into the RSP_* registers, and RSP_ID is set to the grant.
  - The FSM goes to RESP.
- **RESP**
  - RSP_VALID=1, with RSP_* held stable.
  - On RSP_READY the FSM goes to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Requesters must hold VALID and the payload stable until READY. The arbiter never drops an accepted request.
- ALU_* operand outputs keep their last value outside EXEC. ALU_CE is low outside EXEC.

## Timing
- Reset values:
  - State IDLE; `last_grant`=1, so requester 0 wins the first contention.
  - All outputs 0, including ALU_CE, REQn_READY, RSP_VALID, RSP_ID, RSP_RES, all RSP flags, and all ALU_* outputs.
- Latency from the accept edge to RSP_VALID rising is LAT+2 cycles: 3 for normal commands and 5 for multiply commands.
- ALU_CE is high for exactly LAT consecutive cycles per operation.
- Minimum request-to-request spacing per grant is LAT+3 cycles, given RSP_READY tied high.
- Back-to-back contention alternates grants: 0,1,0,1.
- A requester that drops VALID before grant loses no priority state. `last_grant` changes only on handshake.
- RST asserted in any state:
  - The in-flight operation is aborted immediately and no response is issued.
  - All outputs clear asynchronously.
  - After RST deassertion the first IDLE cycle may accept a request.
- RSP_READY high while not in RESP is ignored.

## Configuration
- `ALU_PRECHECK_EN` defined:
  - In IDLE, an accepted request is classed illegal if INP_VALID=00, or if CMD>12 with MODE=1, or if CMD>13 with MODE=0.
  - An illegal request skips EXEC and CAPT and goes directly to RESP with RSP_ERR=1, RSP_RES=0, all other flags 0, and RSP_ID set.
  - RSP_VALID rises 1 cycle after the accept edge, and ALU_CE stays low.
- `ALU_PRECHECK_EN` undefined:
  - Every request is issued to the ALU with LAT_ALU latency.
  - RSP_ERR reflects ALU_ERR.

## Test plan
- Single request: REQ0 with MODE=1, CMD=0, OPA=15, OPB=10, INP_VALID=11 -> RSP_VALID 3 cycles after accept, RSP_RES=25, RSP_ID=0, COUT=0.
- Contention after reset:
  - Stimulus: REQ0 (MODE=0, CMD=0, AA&55) and REQ1 (MODE=1, CMD=0, FF+FF) assert VALID in the same cycle.
  - Required response: REQ0 is granted first with RES=0. REQ1 follows with RES=0x1FE and COUT=1. RSP_ID sequence is 0,1.
- Multiply: REQ1 with MODE=1, CMD=9, OPA=4, OPB=3 -> ALU_CE high exactly 3 cycles, RSP_VALID 5 cycles after accept, RSP_RES=20.
- Backpressure: RSP_READY held low 4 cycles in RESP while REQ0_VALID=1 -> RSP_* stable, REQ0_READY=0 throughout, grant occurs the cycle after the response handshake.
- Precheck: MODE=1, CMD=15, INP_VALID=11:
  - With the macro: RSP_ERR=1, RSP_RES=0, RSP_VALID 1 cycle after accept, ALU_CE never high.
  - Without the macro: 3-cycle latency, RSP_ERR=ALU_ERR.
- Reset mid-EXEC of a CMD=10 operation -> all outputs 0 immediately, no RSP_VALID, and the next contention grants REQ0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one ALU_design instance.
// Optional build macro ALU_PRECHECK_EN: reject illegal requests without running the ALU.
module alu_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int LAT_ALU   = 1,
    parameter int LAT_MUL   = 3
) (
    input  logic                   CLK,
    input  logic                   RST,

    input  logic                   REQ0_VALID,
    output logic                   REQ0_READY,
    input  logic [WIDTH-1:0]       REQ0_OPA,
    input  logic [WIDTH-1:0]       REQ0_OPB,
    input  logic [1:0]             REQ0_INP_VALID,
    input  logic                   REQ0_CIN,
    input  logic                   REQ0_MODE,
    input  logic [CMD_WIDTH-1:0]   REQ0_CMD,

    input  logic                   REQ1_VALID,
    output logic                   REQ1_READY,
    input  logic [WIDTH-1:0]       REQ1_OPA,
    input  logic [WIDTH-1:0]       REQ1_OPB,
    input  logic [1:0]             REQ1_INP_VALID,
    input  logic                   REQ1_CIN,
    input  logic                   REQ1_MODE,
    input  logic [CMD_WIDTH-1:0]   REQ1_CMD,

    output logic                   ALU_CE,
    output logic [WIDTH-1:0]       ALU_OPA,
    output logic [WIDTH-1:0]       ALU_OPB,
    output logic [1:0]             ALU_INP_VALID,
    output logic                   ALU_CIN,
    output logic                   ALU_MODE,
    output logic [CMD_WIDTH-1:0]   ALU_CMD,
    input  logic [2*WIDTH-1:0]     ALU_RES,
    input  logic                   ALU_ERR,
    input  logic                   ALU_COUT,
    input  logic                   ALU_OFLOW,
    input  logic                   ALU_G,
    input  logic                   ALU_E,
    input  logic                   ALU_L,

    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic                   RSP_ID,
    output logic [2*WIDTH-1:0]     RSP_RES,
    output logic                   RSP_ERR,
    output logic                   RSP_COUT,
    output logic                   RSP_OFLOW,
    output logic                   RSP_G,
    output logic                   RSP_E,
    output logic                   RSP_L,

    output logic                   BUSY
);

    localparam int LAT_MAX = (LAT_MUL > LAT_ALU) ? LAT_MUL : LAT_ALU;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]     opa;
        logic [WIDTH-1:0]     opb;
        logic [1:0]           inp_valid;
        logic                 cin;
        logic                 mode;
        logic [CMD_WIDTH-1:0] cmd;
    } req_t;

    state_t           state;
    logic             last_grant;
    logic             cur_id;
    logic [CNT_W-1:0] lat_cnt;

    req_t req0, req1, sel;
    logic grant, accept, is_mul, illegal;

    assign req0 = '{REQ0_OPA, REQ0_OPB, REQ0_INP_VALID, REQ0_CIN, REQ0_MODE, REQ0_CMD};
    assign req1 = '{REQ1_OPA, REQ1_OPB, REQ1_INP_VALID, REQ1_CIN, REQ1_MODE, REQ1_CMD};

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant = REQ1_VALID;
        if (REQ0_VALID && REQ1_VALID)
            grant = ~last_grant;
    end

    // Reset gates READY so nothing is granted while the block is held in reset.
    assign accept     = (state == IDLE) && !RST && (REQ0_VALID || REQ1_VALID);
    assign REQ0_READY = accept && !grant;
    assign REQ1_READY = accept && grant;
    assign sel        = grant ? req1 : req0;
    assign BUSY       = (state != IDLE);

    assign is_mul = sel.mode && (sel.cmd == CMD_WIDTH'(9) || sel.cmd == CMD_WIDTH'(10));

`ifdef ALU_PRECHECK_EN
    assign illegal = (sel.inp_valid == 2'b00)
                   || ( sel.mode && sel.cmd > CMD_WIDTH'(12))
                   || (!sel.mode && sel.cmd > CMD_WIDTH'(13));
`else
    assign illegal = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; every flop here has an async reset value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            cur_id        <= 1'b0;
            lat_cnt       <= '0;
            ALU_CE        <= 1'b0;
            ALU_OPA       <= '0;
            ALU_OPB       <= '0;
            ALU_INP_VALID <= '0;
            ALU_CIN       <= 1'b0;
            ALU_MODE      <= 1'b0;
            ALU_CMD       <= '0;
            RSP_VALID     <= 1'b0;
            RSP_ID        <= 1'b0;
            RSP_RES       <= '0;
            RSP_ERR       <= 1'b0;
            RSP_COUT      <= 1'b0;
            RSP_OFLOW     <= 1'b0;
            RSP_G         <= 1'b0;
            RSP_E         <= 1'b0;
            RSP_L         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        {ALU_OPA, ALU_OPB, ALU_INP_VALID, ALU_CIN, ALU_MODE, ALU_CMD} <= sel;
                        last_grant <= grant;
                        cur_id     <= grant;
                        if (illegal) begin
                            // Rejected request: answer with an error, the ALU is never enabled.
                            state     <= RESP;
                            RSP_VALID <= 1'b1;
                            RSP_ID    <= grant;
                            RSP_RES   <= '0;
                            RSP_ERR   <= 1'b1;
                            RSP_COUT  <= 1'b0;
                            RSP_OFLOW <= 1'b0;
                            RSP_G     <= 1'b0;
                            RSP_E     <= 1'b0;
                            RSP_L     <= 1'b0;
                        end else begin
                            state   <= EXEC;
                            ALU_CE  <= 1'b1;
                            lat_cnt <= is_mul ? CNT_W'(LAT_MUL) : CNT_W'(LAT_ALU);
                        end
                    end
                end
                EXEC: begin
                    if (lat_cnt <= CNT_W'(1)) begin
                        ALU_CE <= 1'b0;
                        state  <= CAPT;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                CAPT: begin
                    // ALU holds its outputs while CE is low, so this sample is stable.
                    RSP_RES   <= ALU_RES;
                    RSP_ERR   <= ALU_ERR;
                    RSP_COUT  <= ALU_COUT;
                    RSP_OFLOW <= ALU_OFLOW;
                    RSP_G     <= ALU_G;
                    RSP_E     <= ALU_E;
                    RSP_L     <= ALU_L;
                    RSP_ID    <= cur_id;
                    RSP_VALID <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus scoreboard, with a stand-in ALU.
// Expectations for illegal commands follow the ALU_PRECHECK_EN build macro.
module tb_alu_arbiter;

    localparam int W  = 8;
    localparam int CW = 4;

`ifdef ALU_PRECHECK_EN
    localparam int ILL_LAT = 1;
    localparam int ILL_CE  = 0;
`else
    localparam int ILL_LAT = 3;
    localparam int ILL_CE  = 1;
`endif

    typedef struct {
        logic [W-1:0]   opa;
        logic [W-1:0]   opb;
        logic [1:0]     iv;
        logic           cin;
        logic           mode;
        logic [CW-1:0]  cmd;
        logic [2*W-1:0] res;
        logic           cout;
        logic           err;
        int             lat;
        int             ce;
    } vec_t;

    typedef struct {
        bit             id;
        logic [2*W-1:0] res;
        logic           cout;
        logic           err;
        int             lat;
        int             ce;
        int             acc_cyc;
    } exp_t;

    logic CLK, RST;
    logic REQ0_VALID, REQ0_READY, REQ0_CIN, REQ0_MODE;
    logic [W-1:0] REQ0_OPA, REQ0_OPB;
    logic [1:0] REQ0_INP_VALID;
    logic [CW-1:0] REQ0_CMD;
    logic REQ1_VALID, REQ1_READY, REQ1_CIN, REQ1_MODE;
    logic [W-1:0] REQ1_OPA, REQ1_OPB;
    logic [1:0] REQ1_INP_VALID;
    logic [CW-1:0] REQ1_CMD;
    logic ALU_CE, ALU_CIN, ALU_MODE;
    logic [W-1:0] ALU_OPA, ALU_OPB;
    logic [1:0] ALU_INP_VALID;
    logic [CW-1:0] ALU_CMD;
    logic [2*W-1:0] ALU_RES;
    logic ALU_ERR, ALU_COUT;
    logic ALU_OFLOW, ALU_G, ALU_E, ALU_L;
    logic RSP_VALID, RSP_READY, RSP_ID;
    logic [2*W-1:0] RSP_RES;
    logic RSP_ERR, RSP_COUT, RSP_OFLOW, RSP_G, RSP_E, RSP_L;
    logic BUSY;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    bit   grant_log[$];
    vec_t tbl[13];

    alu_arbiter #(.WIDTH(W), .CMD_WIDTH(CW), .LAT_ALU(1), .LAT_MUL(3)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OPA(REQ0_OPA), .REQ0_OPB(REQ0_OPB),
        .REQ0_INP_VALID(REQ0_INP_VALID), .REQ0_CIN(REQ0_CIN), .REQ0_MODE(REQ0_MODE), .REQ0_CMD(REQ0_CMD),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OPA(REQ1_OPA), .REQ1_OPB(REQ1_OPB),
        .REQ1_INP_VALID(REQ1_INP_VALID), .REQ1_CIN(REQ1_CIN), .REQ1_MODE(REQ1_MODE), .REQ1_CMD(REQ1_CMD),
        .ALU_CE(ALU_CE), .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_INP_VALID(ALU_INP_VALID),
        .ALU_CIN(ALU_CIN), .ALU_MODE(ALU_MODE), .ALU_CMD(ALU_CMD),
        .ALU_RES(ALU_RES), .ALU_ERR(ALU_ERR), .ALU_COUT(ALU_COUT), .ALU_OFLOW(ALU_OFLOW),
        .ALU_G(ALU_G), .ALU_E(ALU_E), .ALU_L(ALU_L),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_RES(RSP_RES),
        .RSP_ERR(RSP_ERR), .RSP_COUT(RSP_COUT), .RSP_OFLOW(RSP_OFLOW), .RSP_G(RSP_G),
        .RSP_E(RSP_E), .RSP_L(RSP_L), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Stand-in ALU: registers a new result on each enabled edge, holds it while CE is low.
    function automatic logic [2*W+1:0] alu_model(input logic mode, input logic [CW-1:0] cmd,
                                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic [1:0] iv, input logic cin);
        logic [2*W-1:0] r;
        logic err;
        r   = '0;
        err = 1'b0;
        if (iv != 2'b11) err = 1'b1;
        else if (mode) begin
            case (cmd)
                4'd0:    r = {8'h00, a} + {8'h00, b};
                4'd1:    r = {8'h00, a} - {8'h00, b};
                4'd2:    r = {8'h00, a} + {8'h00, b} + {15'h0, cin};
                4'd9:    r = ({8'h00, a} + 16'd1) * ({8'h00, b} + 16'd1);
                4'd10:   r = ({8'h00, a} << 1) * {8'h00, b};
                default: err = 1'b1;
            endcase
        end else begin
            if (cmd == 4'd0) r = {8'h00, a & b};
            else err = 1'b1;
        end
        return {err, r[W], r};
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_RES  <= '0;
            ALU_COUT <= 1'b0;
            ALU_ERR  <= 1'b0;
        end else if (ALU_CE) begin
            {ALU_ERR, ALU_COUT, ALU_RES} <= alu_model(ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_INP_VALID, ALU_CIN);
        end
    end
    assign ALU_OFLOW = 1'b0;
    assign ALU_G     = 1'b0;
    assign ALU_E     = 1'b0;
    assign ALU_L     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic send(input bit port, input vec_t v, input bit push);
        exp_t e;
        if (!port) begin
            {REQ0_OPA, REQ0_OPB, REQ0_INP_VALID, REQ0_CIN, REQ0_MODE, REQ0_CMD} = {v.opa, v.opb, v.iv, v.cin, v.mode, v.cmd};
            REQ0_VALID = 1'b1;
        end else begin
            {REQ1_OPA, REQ1_OPB, REQ1_INP_VALID, REQ1_CIN, REQ1_MODE, REQ1_CMD} = {v.opa, v.opb, v.iv, v.cin, v.mode, v.cmd};
            REQ1_VALID = 1'b1;
        end
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            if ((!port && REQ0_READY) || (port && REQ1_READY)) begin
                grant_log.push_back(port);
                if (push) begin
                    e = '{id: port, res: v.res, cout: v.cout, err: v.err, lat: v.lat, ce: v.ce, acc_cyc: cyc};
                    exp_q.push_back(e);
                end
                @(posedge CLK);
                #1;
                if (!port) REQ0_VALID = 1'b0; else REQ1_VALID = 1'b0;
                return;
            end
        end
        fail_now(port ? "send1_timeout" : "send0_timeout");
        if (!port) REQ0_VALID = 1'b0; else REQ1_VALID = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (exp_q.size() == 0 && !BUSY && !RSP_VALID) return;
        end
        fail_now("drain_timeout");
        exp_q.delete();
    endtask

    // Response monitor: latency and CE-cycle count at RSP_VALID rise, payload at handshake.
    initial begin
        int  ce_cnt;
        bit  prev_v;
        exp_t e;
        ce_cnt = 0;
        prev_v = 1'b0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                ce_cnt = 0;
                prev_v = 1'b0;
            end else begin
                if (ALU_CE) ce_cnt++;
                if (RSP_VALID && !prev_v) begin
                    if (exp_q.size() == 0) fail_now("unexpected_rsp");
                    else begin
                        check("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                        check("ce_cycles", ce_cnt, exp_q[0].ce);
                    end
                    ce_cnt = 0;
                end
                if (RSP_VALID && RSP_READY && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_id", RSP_ID, e.id);
                    check("rsp_res", RSP_RES, e.res);
                    check("rsp_err", RSP_ERR, e.err);
                    check("rsp_cout", RSP_COUT, e.cout);
                    check("rsp_flags", {RSP_OFLOW, RSP_G, RSP_E, RSP_L}, 4'b0000);
                end
                prev_v = RSP_VALID;
            end
        end
    end

    initial begin
        vec_t abort_v;
        logic [2*W-1:0] snap_res;
        //          opa    opb    iv     cin   mode  cmd     res       cout  err   lat      ce
        tbl[0]  = '{8'd15, 8'd10, 2'b11, 1'b0, 1'b1, 4'd0,  16'd25,   1'b0, 1'b0, 3,       1};
        tbl[1]  = '{8'd4,  8'd3,  2'b11, 1'b0, 1'b1, 4'd9,  16'd20,   1'b0, 1'b0, 5,       3};
        tbl[2]  = '{8'hAA, 8'h55, 2'b11, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 3,       1};
        tbl[3]  = '{8'hFF, 8'hFF, 2'b11, 1'b0, 1'b1, 4'd0,  16'h01FE, 1'b1, 1'b0, 3,       1};
        tbl[4]  = '{8'd3,  8'd5,  2'b11, 1'b0, 1'b1, 4'd10, 16'd30,   1'b0, 1'b0, 5,       3};
        tbl[5]  = '{8'd20, 8'd7,  2'b11, 1'b0, 1'b1, 4'd1,  16'd13,   1'b0, 1'b0, 3,       1};
        tbl[6]  = '{8'd1,  8'd2,  2'b11, 1'b0, 1'b1, 4'd15, 16'd0,    1'b0, 1'b1, ILL_LAT, ILL_CE};
        tbl[7]  = '{8'd1,  8'd2,  2'b00, 1'b0, 1'b1, 4'd0,  16'd0,    1'b0, 1'b1, ILL_LAT, ILL_CE};
        tbl[8]  = '{8'd1,  8'd2,  2'b11, 1'b0, 1'b0, 4'd14, 16'd0,    1'b0, 1'b1, ILL_LAT, ILL_CE};
        tbl[9]  = '{8'd1,  8'd2,  2'b11, 1'b0, 1'b1, 4'd12, 16'd0,    1'b0, 1'b1, 3,       1};
        tbl[10] = '{8'd1,  8'd2,  2'b11, 1'b0, 1'b0, 4'd13, 16'd0,    1'b0, 1'b1, 3,       1};
        tbl[11] = '{8'hC3, 8'h0F, 2'b11, 1'b0, 1'b0, 4'd0,  16'h0003, 1'b0, 1'b0, 3,       1};
        tbl[12] = '{8'd10, 8'd20, 2'b11, 1'b1, 1'b1, 4'd2,  16'd31,   1'b0, 1'b0, 3,       1};
        abort_v = '{8'd7,  8'd9,  2'b11, 1'b0, 1'b1, 4'd10, 16'd0,    1'b0, 1'b0, 5,       3};

        {REQ0_OPA, REQ0_OPB, REQ0_INP_VALID, REQ0_CIN, REQ0_MODE, REQ0_CMD} = '0;
        {REQ1_OPA, REQ1_OPB, REQ1_INP_VALID, REQ1_CIN, REQ1_MODE, REQ1_CMD} = '0;
        REQ1_VALID = 1'b0;
        REQ0_VALID = 1'b1;
        RSP_READY  = 1'b1;
        RST        = 1'b1;

        // Reset values, with a request pending that must not be granted.
        repeat (3) @(negedge CLK);
        check("rst_req0_ready", REQ0_READY, 1'b0);
        check("rst_alu_ce", ALU_CE, 1'b0);
        check("rst_rsp_valid", RSP_VALID, 1'b0);
        check("rst_rsp_id_res", {RSP_ID, RSP_RES}, '0);
        check("rst_rsp_flags", {RSP_ERR, RSP_COUT, RSP_OFLOW, RSP_G, RSP_E, RSP_L}, '0);
        check("rst_alu_ops", {ALU_OPA, ALU_OPB, ALU_INP_VALID, ALU_CIN, ALU_MODE, ALU_CMD}, '0);
        check("rst_busy", BUSY, 1'b0);
        REQ0_VALID = 1'b0;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Contention right after reset, both requesters back-to-back: grants 0,1,0,1.
        grant_log.delete();
        fork
            begin send(1'b0, tbl[2], 1'b1); send(1'b0, tbl[0], 1'b1); end
            begin send(1'b1, tbl[3], 1'b1); send(1'b1, tbl[1], 1'b1); end
        join
        wait_drain();
        check("alt_count", grant_log.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < grant_log.size()) check($sformatf("alt_grant%0d", k), grant_log[k], k % 2);

        // Table-driven single requests, alternating ports.
        for (int i = 0; i < 13; i++) begin
            @(posedge CLK);
            #1;
            send(1'(i % 2), tbl[i], 1'b1);
            wait_drain();
        end

        // Backpressure: response held, REQ0 waits, grant the cycle after the handshake.
        @(posedge CLK);
        #1;
        RSP_READY = 1'b0;
        send(1'b1, tbl[0], 1'b1);
        snap_res = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (RSP_VALID) break;
        end
        check("bp_valid_seen", RSP_VALID, 1'b1);
        snap_res = RSP_RES;
        fork send(1'b0, tbl[4], 1'b1); join_none
        repeat (4) begin
            @(negedge CLK);
            check("bp_req0_ready", REQ0_READY, 1'b0);
            check("bp_rsp_stable", {RSP_VALID, RSP_ID, RSP_RES}, {1'b1, 1'b1, snap_res});
        end
        @(posedge CLK);
        #1;
        RSP_READY = 1'b1;
        @(negedge CLK);
        check("bp_hs_req0_ready", REQ0_READY, 1'b0);
        @(negedge CLK);
        check("bp_grant_after", REQ0_READY, 1'b1);
        wait fork;
        wait_drain();

        // Reset in the middle of a multiply: everything clears, no response.
        @(posedge CLK);
        #1;
        send(1'b1, abort_v, 1'b0);
        @(negedge CLK);
        check("abort_ce_high", ALU_CE, 1'b1);
        REQ0_VALID = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        check("abort_ce", ALU_CE, 1'b0);
        check("abort_busy_valid", {BUSY, RSP_VALID}, 2'b00);
        check("abort_ready", {REQ0_READY, REQ1_READY}, 2'b00);
        check("abort_alu_ops", {ALU_OPA, ALU_OPB, ALU_INP_VALID, ALU_CIN, ALU_MODE, ALU_CMD}, '0);
        check("abort_rsp", {RSP_ID, RSP_RES, RSP_ERR, RSP_COUT}, '0);
        REQ0_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            check("abort_no_rsp", RSP_VALID, 1'b0);
        end
        @(posedge CLK);
        #1;
        grant_log.delete();
        fork
            send(1'b0, tbl[0], 1'b1);
            send(1'b1, tbl[1], 1'b1);
        join
        wait_drain();
        check("post_rst_count", grant_log.size(), 2);
        if (grant_log.size() > 0) check("post_rst_first", grant_log[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
